// File: rtl/ccd_line_ctrl.sv
// ---------------------------------------------------------------------------
// ccd_line_ctrl
//
// Purpose:
//   Sequences the readout of one CCD line. An accepted line request first
//   raises the transfer gate (tg) so that charge moves into the shift
//   register. An optional idle gap follows. The controller then enables the
//   downstream pixel clock generator and strobes once per active pixel. A
//   single line_done pulse marks the end of the line.
//
// Build option:
//   CCD_DUMMY_PIX_EN - when defined, DUMMY_N dummy pixel periods are clocked
//                      out between the gap and the active readout. The pixel
//                      clock runs during these periods, but there are no
//                      pix_valid strobes.
//
// Parameters:
//   PIX_DIV  - sys_clk cycles per CCD pixel period (2..8)
//   DUMMY_N  - dummy pixel count (only used with CCD_DUMMY_PIX_EN)
//
// Ports:
//   sys_clk     in   system clock, all logic on rising edge
//   rst         in   synchronous active-high reset
//   line_start  in   one-cycle request to read a line
//   pix_num     in   active pixels per line (sampled on accepted request)
//   tg_len      in   transfer-gate width in cycles (sampled on request)
//   gap_len     in   idle cycles between tg fall and readout (sampled)
//   tg          out  transfer-gate pulse
//   ccd_clk_en  out  enable for the downstream pixel clock generator
//   phase       out  pixel phase 0..PIX_DIV-1 while the pixel clock runs
//   pix_valid   out  one-cycle strobe on the last phase of each active pixel
//   pix_idx     out  0-based index of the active pixel being read
//   busy        out  high whenever a line is in progress
//   line_done   out  one-cycle end-of-line pulse
//   overrun     out  sticky flag: a request arrived while busy
// ---------------------------------------------------------------------------
module ccd_line_ctrl #(
    parameter int PIX_DIV = 5,
    parameter int DUMMY_N = 16
) (
    input  logic        sys_clk,
    input  logic        rst,
    input  logic        line_start,
    input  logic [11:0] pix_num,
    input  logic [7:0]  tg_len,
    input  logic [7:0]  gap_len,
    output logic        tg,
    output logic        ccd_clk_en,
    output logic [2:0]  phase,
    output logic        pix_valid,
    output logic [11:0] pix_idx,
    output logic        busy,
    output logic        line_done,
    output logic        overrun
);

    localparam logic [2:0] PHASE_LAST = 3'(PIX_DIV - 1);

    // Reject parameter values that the 3-bit phase counter or the dummy
    // sequencer cannot represent.
    generate
        if (PIX_DIV < 2 || PIX_DIV > 8 || DUMMY_N < 1) begin : g_param_check
            $error("ccd_line_ctrl: PIX_DIV must be 2..8 and DUMMY_N at least 1");
        end
    endgenerate

`ifdef CCD_DUMMY_PIX_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TG,
        ST_GAP,
        ST_DUMMY,
        ST_READ,
        ST_DONE
    } state_t;

    localparam int DUMMY_W = (DUMMY_N > 1) ? $clog2(DUMMY_N) : 1;
    localparam logic [DUMMY_W-1:0] DUMMY_LAST = DUMMY_W'(DUMMY_N - 1);

    logic [DUMMY_W-1:0] dummy_cnt;
    logic [DUMMY_W-1:0] dummy_cnt_nxt;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TG,
        ST_GAP,
        ST_READ,
        ST_DONE
    } state_t;
`endif

    state_t      state;
    state_t      state_nxt;

    // This counter counts down the remaining cycles of the TG or GAP phase.
    // A value of 1 means this cycle is the final cycle of that phase.
    logic [7:0]  len_cnt;
    logic [7:0]  len_cnt_nxt;

    // These registers hold the line parameters latched from the accepted
    // request.
    logic [11:0] pix_num_q;
    logic [11:0] pix_num_nxt;
    logic [7:0]  gap_len_q;
    logic [7:0]  gap_len_nxt;

    logic [2:0]  phase_nxt;
    logic [11:0] pix_idx_nxt;
    logic        overrun_nxt;
    logic        tg_nxt;
    logic        clk_en_nxt;
    logic        pix_valid_nxt;
    logic        busy_nxt;
    logic        line_done_nxt;

    // Set when the TG or GAP phase ends. The code after the case statement
    // then selects the next phase: dummy pixels, readout, or straight to DONE
    // for an empty line.
    logic        post_gap;

    // Next-state and next-output logic. Every output is a register that
    // loads a value derived from the next state. This keeps the outputs
    // aligned with the state and free of glitches.
    always_comb begin
        state_nxt     = state;
        len_cnt_nxt   = len_cnt;
        pix_num_nxt   = pix_num_q;
        gap_len_nxt   = gap_len_q;
        phase_nxt     = 3'd0;
        pix_idx_nxt   = pix_idx;
        overrun_nxt   = overrun;
        post_gap      = 1'b0;
`ifdef CCD_DUMMY_PIX_EN
        dummy_cnt_nxt = dummy_cnt;
`endif

        case (state)
            ST_IDLE: begin
                if (line_start) begin
                    state_nxt   = ST_TG;
                    pix_num_nxt = pix_num;
                    gap_len_nxt = gap_len;
                    // A zero-length gate still produces a one-cycle pulse.
                    len_cnt_nxt = (tg_len == 8'd0) ? 8'd1 : tg_len;
                    pix_idx_nxt = 12'd0;
                end
            end

            ST_TG: begin
                if (len_cnt == 8'd1) begin
                    if (gap_len_q != 8'd0) begin
                        state_nxt   = ST_GAP;
                        len_cnt_nxt = gap_len_q;
                    end else begin
                        post_gap = 1'b1;
                    end
                end else begin
                    len_cnt_nxt = len_cnt - 8'd1;
                end
            end

            ST_GAP: begin
                if (len_cnt == 8'd1) begin
                    post_gap = 1'b1;
                end else begin
                    len_cnt_nxt = len_cnt - 8'd1;
                end
            end

`ifdef CCD_DUMMY_PIX_EN
            ST_DUMMY: begin
                if (phase == PHASE_LAST) begin
                    if (dummy_cnt == DUMMY_LAST) begin
                        state_nxt = ST_READ;
                    end else begin
                        dummy_cnt_nxt = dummy_cnt + 1'b1;
                    end
                end else begin
                    phase_nxt = phase + 3'd1;
                end
            end
`endif

            ST_READ: begin
                if (phase == PHASE_LAST) begin
                    if (pix_idx == pix_num_q - 12'd1) begin
                        state_nxt = ST_DONE;
                    end else begin
                        pix_idx_nxt = pix_idx + 12'd1;
                    end
                end else begin
                    phase_nxt = phase + 3'd1;
                end
            end

            ST_DONE: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (post_gap) begin
            if (pix_num_q == 12'd0) begin
                state_nxt = ST_DONE;
            end else begin
`ifdef CCD_DUMMY_PIX_EN
                state_nxt     = ST_DUMMY;
                dummy_cnt_nxt = '0;
`else
                state_nxt     = ST_READ;
`endif
            end
        end

        // The controller ignores any request that arrives outside IDLE. That
        // request only sets the sticky overrun flag. The DONE cycle counts as
        // busy.
        if (line_start && (state != ST_IDLE)) begin
            overrun_nxt = 1'b1;
        end

        tg_nxt        = (state_nxt == ST_TG);
        busy_nxt      = (state_nxt != ST_IDLE);
        line_done_nxt = (state_nxt == ST_DONE);
`ifdef CCD_DUMMY_PIX_EN
        clk_en_nxt    = (state_nxt == ST_READ) || (state_nxt == ST_DUMMY);
`else
        clk_en_nxt    = (state_nxt == ST_READ);
`endif
        pix_valid_nxt = (state_nxt == ST_READ) && (phase_nxt == PHASE_LAST);
    end

    // State and output registers. Reset has priority over everything else,
    // so an in-flight line aborts without a line_done pulse.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            len_cnt    <= 8'd0;
            pix_num_q  <= 12'd0;
            gap_len_q  <= 8'd0;
            phase      <= 3'd0;
            pix_idx    <= 12'd0;
            overrun    <= 1'b0;
            tg         <= 1'b0;
            ccd_clk_en <= 1'b0;
            pix_valid  <= 1'b0;
            busy       <= 1'b0;
            line_done  <= 1'b0;
`ifdef CCD_DUMMY_PIX_EN
            dummy_cnt  <= '0;
`endif
        end else begin
            state      <= state_nxt;
            len_cnt    <= len_cnt_nxt;
            pix_num_q  <= pix_num_nxt;
            gap_len_q  <= gap_len_nxt;
            phase      <= phase_nxt;
            pix_idx    <= pix_idx_nxt;
            overrun    <= overrun_nxt;
            tg         <= tg_nxt;
            ccd_clk_en <= clk_en_nxt;
            pix_valid  <= pix_valid_nxt;
            busy       <= busy_nxt;
            line_done  <= line_done_nxt;
`ifdef CCD_DUMMY_PIX_EN
            dummy_cnt  <= dummy_cnt_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_ccd_line_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ccd_line_ctrl
//
// This bench is self-checking for ccd_line_ctrl. A line-level reference
// model predicts every output on every cycle. It records the cycle in which
// each line started, and it computes all outputs from the offset into that
// line using plain arithmetic.
// Packed expectation layout:
//   [20] tg  [19] ccd_clk_en  [18:16] phase  [15] pix_valid
//   [14:3] pix_idx  [2] busy  [1] line_done  [0] overrun
// ---------------------------------------------------------------------------
module tb_ccd_line_ctrl;

    localparam int PD = 5;
    localparam int DN = 2;
`ifdef CCD_DUMMY_PIX_EN
    localparam int DUM_CYC = DN * PD;
`else
    localparam int DUM_CYC = 0;
`endif

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_start = 1'b0;
    logic [11:0] pix_num = 12'd0;
    logic [7:0]  tg_len = 8'd0;
    logic [7:0]  gap_len = 8'd0;
    logic        tg;
    logic        ccd_clk_en;
    logic [2:0]  phase;
    logic        pix_valid;
    logic [11:0] pix_idx;
    logic        busy;
    logic        line_done;
    logic        overrun;

    int checks = 0;
    int failures = 0;
    bit checkOn = 1'b0;

    // Model state: number of edges seen, plus the parameters of the current
    // or most recent line.
    int cyc = 0;
    bit lineAct = 1'b0;
    int t0 = 0;
    int tgN = 0;
    int gapN = 0;
    int pixN = 0;
    bit ovr = 1'b0;

    ccd_line_ctrl #(
        .PIX_DIV (PD),
        .DUMMY_N (DN)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .line_start (line_start),
        .pix_num    (pix_num),
        .tg_len     (tg_len),
        .gap_len    (gap_len),
        .tg         (tg),
        .ccd_clk_en (ccd_clk_en),
        .phase      (phase),
        .pix_valid  (pix_valid),
        .pix_idx    (pix_idx),
        .busy       (busy),
        .line_done  (line_done),
        .overrun    (overrun)
    );

    initial begin
        forever #5 sys_clk = ~sys_clk;
    end

    // This function returns the expected outputs visible during cycle c,
    // where c counts the edges applied so far.
    function automatic logic [20:0] expectVec(input int c);
        int off;
        int ds;
        int rs;
        int doneOff;
        logic eTg;
        logic eEn;
        logic eVal;
        logic eBusy;
        logic eDone;
        int ePh;
        int eIdx;
        eTg = 1'b0;
        eEn = 1'b0;
        eVal = 1'b0;
        eBusy = 1'b0;
        eDone = 1'b0;
        ePh = 0;
        eIdx = 0;
        if (lineAct) begin
            off = c - t0;
            ds = tgN + gapN;
            rs = ds + DUM_CYC;
            doneOff = (pixN == 0) ? ds : rs + pixN * PD;
            eTg = (off < tgN);
            eBusy = (off <= doneOff);
            eDone = (off == doneOff);
            if (pixN != 0) begin
                if (off >= ds && off < rs) begin
                    eEn = 1'b1;
                    ePh = (off - ds) % PD;
                end else if (off >= rs && off < rs + pixN * PD) begin
                    eEn = 1'b1;
                    ePh = (off - rs) % PD;
                    eIdx = (off - rs) / PD;
                    eVal = (ePh == PD - 1);
                end else if (off >= rs + pixN * PD) begin
                    eIdx = pixN - 1;
                end
            end
        end
        return {eTg, eEn, 3'(ePh), eVal, 12'(eIdx), eBusy, eDone, ovr};
    endfunction

    task automatic modelStep(input bit r, input bit ls, input int p, input int t, input int g);
        logic [20:0] cur;
        cur = expectVec(cyc);
        if (r) begin
            lineAct = 1'b0;
            ovr = 1'b0;
        end else if (ls) begin
            if (cur[2]) begin
                ovr = 1'b1;
            end else begin
                lineAct = 1'b1;
                t0 = cyc + 1;
                tgN = (t == 0) ? 1 : t;
                gapN = g;
                pixN = p;
            end
        end
        cyc = cyc + 1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, and then
    // return 1 ns after the edge.
    task automatic applyStimulus(input bit r, input bit ls, input logic [11:0] p,
                                 input logic [7:0] t, input logic [7:0] g);
        rst = r;
        line_start = ls;
        pix_num = p;
        tg_len = t;
        gap_len = g;
        @(posedge sys_clk);
        modelStep(r, ls, int'(p), int'(t), int'(g));
        #1;
    endtask

    // Compare against the model on every falling edge once the first reset
    // edge has passed.
    initial begin
        logic [20:0] got;
        forever begin
            @(negedge sys_clk);
            if (checkOn) begin
                got = {tg, ccd_clk_en, phase, pix_valid, pix_idx, busy, line_done, overrun};
                checkOutput($sformatf("cycle%0d", cyc), 64'(got), 64'(expectVec(cyc)));
            end
        end
    end

    initial begin
        logic [63:0] dTg, dEn, dVal, dDone, dBusy, dOvr;
        logic [63:0] mTg, mEn, mVal, mDone;
        logic [63:0] expEn, expVal, expDone, expBusy;
        logic [20:0] ev;
        logic [15:0] idxLog;
        int cnt;
        int lastIdx;
        bit doneSeen;

`ifdef CCD_DUMMY_PIX_EN
        expEn   = 64'h0000_000F_FFFF_FFC0;
        expVal  = 64'h0000_0008_4210_0000;
        expDone = 64'h0000_0010_0000_0000;
        expBusy = 64'h0000_001F_FFFF_FFFE;
`else
        expEn   = 64'h0000_0000_03FF_FFC0;
        expVal  = 64'h0000_0000_0210_8400;
        expDone = 64'h0000_0000_0400_0000;
        expBusy = 64'h0000_0000_07FF_FFFE;
`endif

        applyStimulus(1, 0, 12'd0, 8'd0, 8'd0);
        checkOn = 1'b1;
        applyStimulus(1, 1, 12'd7, 8'd2, 8'd2);
        checkOutput("reset_state",
                    64'({tg, ccd_clk_en, phase, pix_valid, pix_idx, busy, line_done, overrun}), 64'd0);

        // Reference line: pix=4, tg=3, gap=2. A second request arrives at
        // cycle 8, and the inputs change mid-line.
        dTg = '0; dEn = '0; dVal = '0; dDone = '0; dBusy = '0; dOvr = '0;
        mTg = '0; mEn = '0; mVal = '0; mDone = '0;
        idxLog = '0;
        applyStimulus(0, 1, 12'd4, 8'd3, 8'd2);
        for (int c = 1; c <= 40; c++) begin
            ev = expectVec(cyc);
            dTg[c] = tg;
            dEn[c] = ccd_clk_en;
            dVal[c] = pix_valid;
            dDone[c] = line_done;
            dBusy[c] = busy;
            dOvr[c] = overrun;
            mTg[c] = ev[20];
            mEn[c] = ev[19];
            mVal[c] = ev[15];
            mDone[c] = ev[1];
            if (pix_valid) idxLog = {idxLog[11:0], pix_idx[3:0]};
            applyStimulus(0, (c == 8), 12'd9, 8'd7, 8'd1);
        end
        checkOutput("ref_tg", dTg, 64'h0000_0000_0000_000E);
        checkOutput("ref_clk_en", dEn, expEn);
        checkOutput("ref_pix_valid", dVal, expVal);
        checkOutput("ref_line_done", dDone, expDone);
        checkOutput("ref_busy", dBusy, expBusy);
        checkOutput("ref_overrun", dOvr, 64'h0000_01FF_FFFF_FE00);
        checkOutput("ref_idx_seq", 64'(idxLog), 64'h0123);
        checkOutput("model_tg", mTg, 64'h0000_0000_0000_000E);
        checkOutput("model_clk_en", mEn, expEn);
        checkOutput("model_pix_valid", mVal, expVal);
        checkOutput("model_line_done", mDone, expDone);

        // Empty line with zero gate and zero gap.
        applyStimulus(1, 0, 12'd0, 8'd0, 8'd0);
        dTg = '0; dVal = '0; dDone = '0; dBusy = '0;
        applyStimulus(0, 1, 12'd0, 8'd0, 8'd0);
        for (int c = 1; c <= 6; c++) begin
            dTg[c] = tg;
            dVal[c] = pix_valid;
            dDone[c] = line_done;
            dBusy[c] = busy;
            applyStimulus(0, 0, 12'd0, 8'd0, 8'd0);
        end
        checkOutput("empty_tg", dTg, 64'h2);
        checkOutput("empty_line_done", dDone, 64'h4);
        checkOutput("empty_pix_valid", dVal, 64'h0);
        checkOutput("empty_busy", dBusy, 64'h6);

        // Reset asserted during cycle 12 of the reference line.
        dDone = '0;
        applyStimulus(0, 1, 12'd4, 8'd3, 8'd2);
        for (int c = 1; c <= 30; c++) begin
            dDone[c] = line_done;
            if (c == 13) begin
                checkOutput("abort_outputs_zero",
                            64'({tg, ccd_clk_en, phase, pix_valid, pix_idx, busy, line_done, overrun}), 64'd0);
            end
            applyStimulus((c == 12), 0, 12'd4, 8'd3, 8'd2);
        end
        checkOutput("abort_no_line_done", dDone, 64'h0);

        // Longest line: every pixel index must appear without wrapping.
        cnt = 0;
        lastIdx = -1;
        doneSeen = 1'b0;
        applyStimulus(0, 1, 12'd4095, 8'd1, 8'd0);
        for (int c = 1; c <= 4095 * PD + DUM_CYC + 50; c++) begin
            if (pix_valid) begin
                cnt = cnt + 1;
                lastIdx = int'(pix_idx);
            end
            if (line_done) begin
                doneSeen = 1'b1;
                break;
            end
            applyStimulus(0, 0, 12'd4095, 8'd1, 8'd0);
        end
        checkOutput("max_line_done_seen", 64'(doneSeen), 64'd1);
        checkOutput("max_pix_count", 64'(cnt), 64'd4095);
        checkOutput("max_last_idx", 64'(lastIdx), 64'd4094);

        // Randomised traffic. This mixes requests, mid-line input changes,
        // overlapping requests, and occasional resets.
        for (int i = 0; i < 6000; i++) begin
            applyStimulus(($urandom_range(0, 399) == 0),
                          ($urandom_range(0, 14) == 0),
                          12'($urandom_range(0, 20)),
                          8'($urandom_range(0, 6)),
                          8'($urandom_range(0, 6)));
        end

        applyStimulus(0, 0, 12'd0, 8'd0, 8'd0);
        @(negedge sys_clk);
        #1;
        checkOn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
